// File: rtl/root_channel_arb.sv
// Multi-channel round-robin arbiter: one skid entry per input channel feeding a
// single registered output stage, plus a saturating count of completed transfers.

module rca_lane #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] din_i,
  output logic              full_o,
  output logic [DATA_W-1:0] dout_o
);
  logic              full_q;
  logic [DATA_W-1:0] data_q;

  // load and clear never coincide: load needs the entry empty, clear needs it full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (load_i) begin
      full_q <= 1'b1;
      data_q <= din_i;
    end else if (clr_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign dout_o = data_q;
endmodule

module root_channel_arb #(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic [CNT_W-1:0]         out_count
);
  logic [NUM_CH-1:0][DATA_W-1:0] din_pk, buf_q;
  logic [NUM_CH-1:0]             full_q, load, clr;
  logic [CH_W-1:0]               gnt_idx, cand;
  logic                          gnt_vld, gnt, out_free;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d, last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign din_pk   = in_data;
  assign in_ready = ~full_q;
  assign load     = in_valid & ~full_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    rca_lane #(.DATA_W(DATA_W)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (load[g]),
      .clr_i  (clr[g]),
      .din_i  (din_pk[g]),
      .full_o (full_q[g]),
      .dout_o (buf_q[g])
    );
  end

  // Walk offsets from farthest to nearest so the channel right after last_q wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = CH_W'((int'(last_q) + k) % NUM_CH);
      if (full_q[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign out_free = ~out_valid_q | out_ready;
  assign gnt      = out_free & enable & gnt_vld;

  always_comb begin
    clr = '0;
    if (gnt) clr[gnt_idx] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    last_d      = last_q;
    if (out_free) begin
      out_valid_d = gnt;
      if (gnt) begin
        out_data_d = buf_q[gnt_idx];
        out_ch_d   = gnt_idx;
        last_d     = gnt_idx;
      end
    end
    cnt_d = cnt_q;
    if (out_valid_q && out_ready && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      last_q      <= CH_W'(NUM_CH - 1);
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_count = cnt_q;
endmodule

// File: tb/tb_root_channel_arb.sv
// Directed bench for root_channel_arb: inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge.

module tb_root_channel_arb;
  localparam int NUM_CH = 5;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
  localparam int CH_W   = 3;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     enable = 1'b1;
  logic [NUM_CH-1:0]        in_valid = '0;
  logic [NUM_CH-1:0]        in_ready;
  logic [NUM_CH*DATA_W-1:0] in_data = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic [DATA_W-1:0]        out_data;
  logic [CH_W-1:0]          out_ch;
  logic [CNT_W-1:0]         out_count;

  root_channel_arb #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic set_data(input int ch, input logic [DATA_W-1:0] d);
    in_data[ch*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset;
    rst_n    = 1'b0;
    in_valid = '0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int hs;

    // reset state, then single payload on channel 2
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'h1f);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_ch", 32'(out_ch), 0);
    chk("rst_out_count", 32'(out_count), 0);
    tick();
    rst_n = 1'b1;
    set_data(2, 8'hA5);
    in_valid = 5'b00100;
    smp(); tick();
    in_valid = '0;
    smp();
    chk("t1_in_ready_c1", 32'(in_ready), 32'h1b);
    chk("t1_valid_c1", 32'(out_valid), 0);
    tick(); smp();
    chk("t1_valid_c2", 32'(out_valid), 1);
    chk("t1_data_c2", 32'(out_data), 32'hA5);
    chk("t1_ch_c2", 32'(out_ch), 2);
    tick(); smp();
    chk("t1_count_c3", 32'(out_count), 1);
    chk("t1_valid_c3", 32'(out_valid), 0);

    // all five channels full; reset restores channel-0-first priority
    tick();
    do_reset();
    for (int i = 0; i < NUM_CH; i++) set_data(i, DATA_W'(8'h10 + i));
    in_valid = 5'b11111;
    tick();
    in_valid = '0;
    tick();
    for (int i = 0; i < NUM_CH; i++) begin
      smp();
      chk("t2_valid", 32'(out_valid), 1);
      chk("t2_ch", 32'(out_ch), 32'(i));
      chk("t2_data", 32'(out_data), 32'(8'h10 + i));
      tick();
    end
    smp();
    chk("t2_count", 32'(out_count), 5);
    chk("t2_valid_end", 32'(out_valid), 0);

    // channels 1 and 3 continuously valid: strict alternation
    tick();
    set_data(1, 8'h31);
    set_data(3, 8'h33);
    in_valid = 5'b01010;
    tick(); tick();
    for (int i = 0; i < 6; i++) begin
      smp();
      chk("t3_valid", 32'(out_valid), 1);
      chk("t3_ch", 32'(out_ch), (i % 2 == 0) ? 32'd1 : 32'd3);
      chk("t3_data", 32'(out_data), (i % 2 == 0) ? 32'h31 : 32'h33);
      tick();
    end
    in_valid = '0;

    // backpressure hold for 4 cycles
    do_reset();
    out_ready = 1'b0;
    set_data(0, 8'h40);
    set_data(1, 8'h41);
    in_valid = 5'b00011;
    tick();
    in_valid = '0;
    tick();
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("t4_valid", 32'(out_valid), 1);
      chk("t4_data", 32'(out_data), 32'h40);
      chk("t4_ch", 32'(out_ch), 0);
      chk("t4_in_ready", 32'(in_ready), 32'h1d);
      chk("t4_count", 32'(out_count), 0);
      tick();
    end
    out_ready = 1'b1;
    smp();
    chk("t4_data_rel", 32'(out_data), 32'h40);
    tick(); smp();
    chk("t4_ch_next", 32'(out_ch), 1);
    chk("t4_data_next", 32'(out_data), 32'h41);
    chk("t4_count_next", 32'(out_count), 1);
    tick(); smp();
    chk("t4_valid_end", 32'(out_valid), 0);
    chk("t4_count_end", 32'(out_count), 2);

    // enable low blocks grants but not buffering
    tick();
    enable = 1'b0;
    set_data(0, 8'h55);
    in_valid = 5'b00001;
    tick();
    in_valid = '0;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("t5_valid_off", 32'(out_valid), 0);
      chk("t5_in_ready", 32'(in_ready), 32'h1e);
      tick();
    end
    enable = 1'b1;
    smp();
    chk("t5_valid_en", 32'(out_valid), 0);
    tick(); smp();
    chk("t5_valid_on", 32'(out_valid), 1);
    chk("t5_data_on", 32'(out_data), 32'h55);
    chk("t5_ch_on", 32'(out_ch), 0);

    // 20 handshakes saturate a 4-bit counter, then reset mid-burst
    tick();
    do_reset();
    set_data(0, 8'h60);
    set_data(1, 8'h61);
    in_valid  = 5'b00011;
    out_ready = 1'b1;
    hs = 0;
    for (int c = 0; c < 60 && hs < 20; c++) begin
      smp();
      if (out_valid) hs++;
      tick();
    end
    chk("t6_hs_reached", 32'(hs), 20);
    smp();
    chk("t6_count_sat", 32'(out_count), 15);
    chk("t6_valid_mid", 32'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 0);
    chk("t6_rst_data", 32'(out_data), 0);
    chk("t6_rst_ch", 32'(out_ch), 0);
    chk("t6_rst_count", 32'(out_count), 0);
    chk("t6_rst_in_ready", 32'(in_ready), 32'h1f);
    in_valid = '0;
    tick();
    rst_n = 1'b1;
    smp();
    chk("t6_post_valid", 32'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/root_channel_arb.md
ROOT_CHANNEL_ARB -- requirements
Module: root_channel_arb

Interface
REQ-001 SHALL have parameter NUM_CH, default 5, number of input channels (legal 2..16).
REQ-002 SHALL have parameter DATA_W, default 8, payload width per channel (legal 1..64).
REQ-003 SHALL have parameter CNT_W, default 16, width of transfer counter.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  arbitration enable; 0 freezes new grants.
REQ-007 SHALL have port in_valid  input  NUM_CH  per-channel valid, bit i = channel i.
REQ-008 SHALL have port in_ready  output  NUM_CH  per-channel ready.
REQ-009 SHALL have port in_data  input  NUM_CH*DATA_W  channel i in bits [i*DATA_W +: DATA_W].
REQ-010 SHALL have port out_valid  output  1  output payload valid.
REQ-011 SHALL have port out_ready  input  1  downstream ready.
REQ-012 SHALL have port out_data  output  DATA_W  granted payload.
REQ-013 SHALL have port out_ch  output  max(1,$clog2(NUM_CH))  index of channel that sourced out_data.
REQ-014 SHALL have port out_count  output  CNT_W  number of completed output handshakes.

Function
REQ-015 SHALL hold one buffer entry (data + full flag) per channel.
REQ-016 SHALL drive in_ready[i] = NOT full[i], with no combinational path from out_ready or in_valid.
REQ-017 SHALL load buffer i and set full[i] at the edge where in_valid[i] & in_ready[i].
REQ-018 SHALL have a single output register (out_data, out_ch, out_valid); "output free" = NOT out_valid OR out_ready.
REQ-019 SHALL, when output free and enable=1 and any full[i], grant exactly one channel round-robin: search starting at last_grant+1 modulo NUM_CH.
REQ-020 SHALL, on grant, load output register from the granted buffer, clear its full flag, and update last_grant to the granted index, all at the same edge.
REQ-021 SHALL, when output free and no grant occurs, clear out_valid at that edge.
REQ-022 SHALL hold out_data and out_ch stable while out_valid=1 and out_ready=0.
REQ-023 SHALL yield latency 2 cycles: handshake at input in cycle N -> earliest out_valid=1 in cycle N+2.
REQ-024 SHALL sustain one output per cycle when two or more channels hold data; a single channel sustains one per 2 cycles.
REQ-025 SHALL keep the output register and buffer loading unaffected by enable=0; only new grants stop.
REQ-026 SHALL increment out_count on each out_valid & out_ready edge, saturating at 2^CNT_W-1.
REQ-027 SHALL never grant a channel whose full flag is 0, and never drop or duplicate a payload.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force full[*]=0, out_valid=0, out_data=0, out_ch=0, out_count=0, last_grant=NUM_CH-1 (channel 0 has first priority), so in_ready resets to all ones.
REQ-029 SHALL discard buffered and in-flight payloads on reset mid-operation; first grant after release follows REQ-028 priority.
REQ-030 SHALL deassert reset synchronously to clk in the surrounding system; the block does not resynchronise rst_n.

Verification
REQ-031 Reset release, channel 2 sends 0xA5 in cycle 0, out_ready=1 -> out_valid=1 in cycle 2 with out_data=0xA5, out_ch=2; out_count=1 after that cycle.
REQ-032 All 5 channels full (data 0x10..0x14), out_ready=1 -> out_ch sequence 0,1,2,3,4 on consecutive cycles, out_count=5.
REQ-033 Channels 1 and 3 continuously valid, out_ready=1 -> out_ch alternates 1,3,1,3; no channel starved.
REQ-034 out_valid=1 with out_ready=0 for 4 cycles -> out_data/out_ch unchanged, in_ready of full channels stays 0, out_count unchanged.
REQ-035 enable=0 with channel 0 full -> no new out_valid; enable=1 -> out_valid next cycle with channel 0 data.
REQ-036 CNT_W=4, 20 handshakes -> out_count saturates at 15; rst_n pulse mid-burst -> all outputs zero, in_ready all ones immediately.
